maze_blaster: RTL

- Write-side counterpart of the maze lookup block: it modifies the shared 32x32 maze RAM when a bomb explodes.
- Accepts an explosion request (cell coordinates and range) and walks the flame in four directions.
- Destroys breakable bricks by read-modify-write on the maze RAM.
- Sits between the bomb controller and the maze RAM's second port. The renderer keeps reading the RAM through its own port.

---
 rtl/maze_blaster.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/maze_blaster.sv
// maze_blaster: destroys breakable bricks in the shared 32x32 maze RAM when a bomb explodes.
// The flame starts next to the bomb cell and walks +X, -X, +Y, -Y in that order.
// Each cell is handled with a read-check-(write) sequence on the RAM's second port.
// An EMPTY cell lets the flame continue.
// A BRICK cell is overwritten and stops the flame in that direction.
// Any other tile stops the flame without being written.
//
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   req_valid/req_ready         explosion request handshake (ready only in IDLE)
//   req_cellX/req_cellY         bomb cell; req_range flame length 0..7 per direction
//   mem_addr/mem_rdata          RAM address {cellY, cellX}; read data one cycle after address
//   mem_we/mem_wdata            single-cycle tile write
//   busy, done                  activity level, one-cycle completion pulse
//   destroyed_count             bricks destroyed by the last request (saturates at 15)
//
// Optional feature: define MAZE_BONUS_EN to enable the LFSR.
// With the LFSR enabled, some destroyed bricks are written as bonus tiles (4'h3) instead of EMPTY.
module maze_blaster #(
  parameter int unsigned MAZEX = 25,
  parameter int unsigned MAZEY = 17,
  parameter logic [3:0]  BRICK = 4'h2,
  parameter logic [3:0]  EMPTY = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_cellX,
  input  logic [4:0] req_cellY,
  input  logic [2:0] req_range,
  output logic [9:0] mem_addr,
  input  logic [3:0] mem_rdata,
  output logic       mem_we,
  output logic [3:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic [3:0] destroyed_count
);

  localparam int unsigned CW = 5;   // cell coordinate width
  localparam int unsigned AW = 6;   // arithmetic width for bounds detection
  localparam int unsigned SW = 4;   // step width: must hold range+1 = 8

  typedef enum logic [2:0] {IDLE, STEP, READ, CHECK, WRITE, DONE} state_t;
  typedef enum logic [1:0] {DIR_PX, DIR_NX, DIR_PY, DIR_NY} dir_t;

  state_t        state, state_n;
  dir_t          dir, dir_n;
  logic [SW-1:0] step, step_n, step_inc;
  logic [CW-1:0] cell_x, cell_y;
  logic [2:0]    range_q;
  logic [CW-1:0] cur_x, cur_y, cur_x_n, cur_y_n;
  logic [AW-1:0] nx, ny;
  logic          off_map, accept;
  logic [3:0]    wdata_c;

`ifdef MAZE_BONUS_EN
  logic [15:0] lfsr;

  // Galois LFSR, taps 16,14,13,11; free-running every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign wdata_c = (lfsr[2:0] == 3'd0) ? 4'h3 : EMPTY;
`else
  assign wdata_c = EMPTY;
`endif

  assign accept   = req_valid && (state == IDLE);
  assign step_inc = step + SW'(1);

  // Candidate cell for the next step.
  // Underflow below 0 wraps to a large unsigned value, so one upper-bound compare covers both edges.
  always_comb begin
    nx = AW'(cell_x);
    ny = AW'(cell_y);
    unique case (dir)
      DIR_PX: nx = AW'(cell_x) + AW'(step_inc);
      DIR_NX: nx = AW'(cell_x) - AW'(step_inc);
      DIR_PY: ny = AW'(cell_y) + AW'(step_inc);
      DIR_NY: ny = AW'(cell_y) - AW'(step_inc);
      default: ;
    endcase
    off_map = (nx >= AW'(MAZEX)) || (ny >= AW'(MAZEY));
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    dir_n   = dir;
    step_n  = step;
    cur_x_n = cur_x;
    cur_y_n = cur_y;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = STEP;
          dir_n   = DIR_PX;
          step_n  = '0;
        end
      end
      STEP: begin
        if ((step_inc > SW'(range_q)) || off_map) begin
          step_n = '0;
          if (dir == DIR_NY) state_n = DONE;
          else               dir_n   = dir_t'(2'(dir) + 2'd1);
        end else begin
          step_n  = step_inc;
          cur_x_n = nx[CW-1:0];
          cur_y_n = ny[CW-1:0];
          state_n = READ;
        end
      end
      READ: state_n = CHECK;
      CHECK: begin
        if (mem_rdata == EMPTY) begin
          state_n = STEP;
        end else if (mem_rdata == BRICK) begin
          state_n = WRITE;
        end else begin
          step_n = '0;
          if (dir == DIR_NY) begin
            state_n = DONE;
          end else begin
            state_n = STEP;
            dir_n   = dir_t'(2'(dir) + 2'd1);
          end
        end
      end
      WRITE: begin
        // a destroyed brick stops the flame in this direction
        step_n = '0;
        if (dir == DIR_NY) begin
          state_n = DONE;
        end else begin
          state_n = STEP;
          dir_n   = dir_t'(2'(dir) + 2'd1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      dir             <= DIR_PX;
      step            <= '0;
      cell_x          <= '0;
      cell_y          <= '0;
      range_q         <= '0;
      cur_x           <= '0;
      cur_y           <= '0;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      destroyed_count <= '0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      step      <= step_n;
      cur_x     <= cur_x_n;
      cur_y     <= cur_y_n;
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      mem_we    <= (state_n == WRITE);
      if (accept) begin
        cell_x          <= req_cellX;
        cell_y          <= req_cellY;
        range_q         <= req_range;
        destroyed_count <= '0;
      end
      // address is presented during READ and held through CHECK and WRITE
      if (state_n == READ)  mem_addr  <= {cur_y_n, cur_x_n};
      if (state_n == WRITE) mem_wdata <= wdata_c;
      if ((state == WRITE) && (destroyed_count != 4'hF))
        destroyed_count <= destroyed_count + 4'd1;
    end
  end

endmodule
